sipo_frame_controller: RTL and testbench

SIPO_FRAME_CONTROLLER -- requirements
Module: sipo_frame_controller

---
 rtl/sipo_frame_controller.sv | 123 ++++++++++++
 tb/tb_sipo_frame_controller.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_frame_controller.sv
// Serial-in parallel-out frame receiver: start bit, WIDTH data bits MSB first,
// valid/ready handoff with sticky overrun. Define SIPO_FRAME_PARITY_EN to add an even-parity bit.
module sipo_frame_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef SIPO_FRAME_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shifted;
  logic             cap;
  logic [WIDTH-1:0] cap_word;
`ifdef SIPO_FRAME_PARITY_EN
  logic             cap_perr;
  logic             perr_r;
`endif

  assign shifted = {q[WIDTH-2:0], d};

  // Capture decode: the edge that completes a frame delivers a word
  always_comb begin
    cap      = 1'b0;
    cap_word = shifted;
`ifdef SIPO_FRAME_PARITY_EN
    cap_perr = 1'b0;
    if (state == PAR) begin
      cap      = 1'b1;
      cap_word = q;
      cap_perr = ^q ^ d;
    end
`else
    if (state == SHIFT && cnt == LAST) cap = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      q       <= '0;
      data    <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      perr_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (d) begin
            state <= SHIFT;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          q   <= shifted;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
`ifdef SIPO_FRAME_PARITY_EN
            state <= PAR;
`else
            state <= IDLE;
            busy  <= 1'b0;
`endif
          end
        end
`ifdef SIPO_FRAME_PARITY_EN
        PAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A held, unconsumed word wins over a new one; the new one is dropped
      if (cap) begin
        if (valid && !ready) begin
          overrun <= 1'b1;
        end else begin
          data   <= cap_word;
          valid  <= 1'b1;
`ifdef SIPO_FRAME_PARITY_EN
          perr_r <= cap_perr;
`endif
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef SIPO_FRAME_PARITY_EN
  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_frame_controller.sv
// Bench for sipo_frame_controller (WIDTH=4): vector table, directed corner sequences,
// and randomized traffic against a frame-level reference model.
module tb_sipo_frame_controller;

  localparam int W = 4;
`ifdef SIPO_FRAME_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FRAME_BITS = W + PAR_EN;

  logic         clk = 1'b0;
  logic         reset, d, ready;
  logic [W-1:0] q, data;
  logic         valid, busy, overrun, parity_err;

  int n_vec = 0;
  int n_err = 0;

  sipo_frame_controller #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .d(d), .ready(ready),
    .q(q), .data(data), .valid(valid), .busy(busy),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         d;
    logic         rdy;
    logic [W-1:0] q;
    logic [W-1:0] data;
    logic         valid;
    logic         busy;
    logic         perr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic dv, rv, input logic [W-1:0] qv, dav, input logic vv, bv, pv);
    vec_t v;
    v = '{d: dv, rdy: rv, q: qv, data: dav, valid: vv, busy: bv, perr: pv};
    tbl.push_back(v);
  endtask

  task automatic step(input logic dv, input logic rv);
    d = dv;
    ready = rv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    d = 1'b0;
    ready = 1'b0;
    reset = 1'b1;
    #3;
    reset = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] word, input logic pbit, input logic rlast);
    step(1'b1, 1'b0);
    for (int i = W - 1; i >= 0; i--)
      step(word[i], (i == 0 && PAR_EN == 0) ? rlast : 1'b0);
    if (PAR_EN != 0) step(pbit, rlast);
    d = 1'b0;
    ready = 1'b0;
  endtask

  // Frame-level reference model
  logic         m_in_frame;
  logic         m_bits[$];
  logic [W-1:0] m_q, m_data;
  logic         m_valid, m_ovr, m_perr;

  task automatic model_reset();
    m_in_frame = 1'b0;
    m_bits.delete();
    m_q = '0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
  endtask

  task automatic model_edge(input logic dv, input logic rv);
    logic         done;
    int           word;
    int           ones;
    done = 1'b0;
    if (!m_in_frame) begin
      if (dv) begin
        m_in_frame = 1'b1;
        m_bits.delete();
      end
    end else begin
      m_bits.push_back(dv);
      if (m_bits.size() <= W) m_q = W'((int'(m_q) * 2 + int'(dv)) % (1 << W));
      if (m_bits.size() == FRAME_BITS) begin
        done = 1'b1;
        m_in_frame = 1'b0;
      end
    end
    if (done) begin
      word = 0;
      ones = 0;
      for (int i = 0; i < W; i++) word = word * 2 + int'(m_bits[i]);
      for (int i = 0; i < FRAME_BITS; i++) ones += int'(m_bits[i]);
      if (m_valid && !rv) m_ovr = 1'b1;
      else begin
        m_data  = W'(word);
        m_valid = 1'b1;
        m_perr  = (PAR_EN != 0) && (ones % 2 == 1);
      end
    end else if (m_valid && rv) begin
      m_valid = 1'b0;
    end
  endtask

  initial begin
    // One frame 1011 with ready low, then a one-cycle ready pulse
    add(1, 0, 4'h0, 4'h0, 0, 1, 0);
    add(1, 0, 4'h1, 4'h0, 0, 1, 0);
    add(0, 0, 4'h2, 4'h0, 0, 1, 0);
    add(1, 0, 4'h5, 4'h0, 0, 1, 0);
`ifdef SIPO_FRAME_PARITY_EN
    add(1, 0, 4'hB, 4'h0, 0, 1, 0);
    add(1, 0, 4'hB, 4'hB, 1, 0, 0);
`else
    add(1, 0, 4'hB, 4'hB, 1, 0, 0);
`endif
    add(0, 0, 4'hB, 4'hB, 1, 0, 0);
    add(0, 1, 4'hB, 4'hB, 0, 0, 0);
    add(0, 0, 4'hB, 4'hB, 0, 0, 0);
    add(0, 1, 4'hB, 4'hB, 0, 0, 0);

    reset = 1'b1;
    d = 1'b0;
    ready = 1'b0;
    #10;
    reset = 1'b0;
    #50;
    chk("reset_q", 32'(q), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_data", 32'(data), 0);
    chk("reset_overrun", 32'(overrun), 0);

    foreach (tbl[i]) begin
      step(tbl[i].d, tbl[i].rdy);
      chk($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("tbl%0d_data", i), 32'(data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_perr", i), 32'(parity_err), 32'(tbl[i].perr));
    end

    // Back-to-back frames, second dropped
    do_reset();
    send_frame(4'b1011, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("ovr_data", 32'(data), 32'hB);
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_valid", 32'(valid), 1);
    step(1'b0, 1'b1);
    chk("ovr_sticky", 32'(overrun), 1);

    // Back-to-back frames, second accepted on the consuming edge
    do_reset();
    send_frame(4'b1011, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b1);
    chk("swap_data", 32'(data), 32'h6);
    chk("swap_valid", 32'(valid), 1);
    chk("swap_overrun", 32'(overrun), 0);

    // Mid-frame asynchronous reset
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("mid_q_pre", 32'(q), 32'hB);
    reset = 1'b1;
    #1;
    chk("mid_q", 32'(q), 0);
    chk("mid_data", 32'(data), 0);
    chk("mid_valid", 32'(valid), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_overrun", 32'(overrun), 0);
    chk("mid_perr", 32'(parity_err), 0);
    #6;
    reset = 1'b0;
    step(1'b0, 1'b0);
    send_frame(4'b0101, 1'b0, 1'b0);
    chk("post_data", 32'(data), 32'h5);
    chk("post_valid", 32'(valid), 1);

`ifdef SIPO_FRAME_PARITY_EN
    do_reset();
    send_frame(4'b1011, 1'b1, 1'b0);
    chk("par_ok_data", 32'(data), 32'hB);
    chk("par_ok_perr", 32'(parity_err), 0);
    step(1'b0, 1'b1);
    send_frame(4'b1011, 1'b0, 1'b0);
    chk("par_bad_perr", 32'(parity_err), 1);
    chk("par_bad_valid", 32'(valid), 1);
`endif

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic dv, rv;
      if (c % 600 == 599) begin
        do_reset();
        model_reset();
      end
      dv = ($urandom_range(0, 2) == 0);
      rv = ($urandom_range(0, 3) == 0);
      step(dv, rv);
      model_edge(dv, rv);
      chk("rnd_q", 32'(q), 32'(m_q));
      chk("rnd_data", 32'(data), 32'(m_data));
      chk("rnd_valid", 32'(valid), 32'(m_valid));
      chk("rnd_busy", 32'(busy), 32'(m_in_frame));
      chk("rnd_overrun", 32'(overrun), 32'(m_ovr));
      chk("rnd_perr", 32'(parity_err), 32'(m_perr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
